// File: rtl/fft_pkg.sv
// Shared state encoding and radix-4 index helpers for the FFT frame controller.
package fft_pkg;

    typedef enum logic [1:0] {StLoad, StStart, StCompute, StUnload} state_e;

    localparam int unsigned MaxDigits = 16;

    // Bank of a sample index: sum of its base-4 digits, mod 4.
    function automatic logic [1:0] bank_sel(input logic [31:0] idx, input int unsigned n_log2);
        logic [1:0] acc;
        acc = 2'd0;
        for (int unsigned i = 0; i < MaxDigits; i++) begin
            if (i < n_log2 / 2) acc = acc + idx[2*i +: 2];
        end
        return acc;
    endfunction

    function automatic logic [31:0] digit_rev4(input logic [31:0] idx, input int unsigned n_log2);
        logic [31:0] res;
        res = '0;
        for (int unsigned i = 0; i < MaxDigits; i++) begin
            if (i < n_log2 / 2) res = {res[29:0], idx[2*i +: 2]};
        end
        return res;
    endfunction

endpackage

// File: rtl/fft_skid_buf.sv
// Two-entry skid buffer between the bank read pipeline and the result stream.
module fft_skid_buf #(
    parameter int unsigned Width = 18
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [Width-1:0] push_data_i,
    input  logic             ready_i,
    output logic             valid_o,
    output logic [Width-1:0] data_o,
    output logic [1:0]       count_o
);

    logic [Width-1:0] ent0_q, ent0_d, ent1_q, ent1_d;
    logic [1:0]       cnt_q, cnt_d, cnt_after_pop;
    logic             pop;

    assign valid_o = (cnt_q != 2'd0);
    assign data_o  = ent0_q;
    assign count_o = cnt_q;
    assign pop     = valid_o & ready_i;
    assign cnt_after_pop = cnt_q - {1'b0, pop};

    always_comb begin
        ent0_d = ent0_q;
        ent1_d = ent1_q;
        cnt_d  = cnt_after_pop;
        if (pop) ent0_d = ent1_q;
        if (push_i) begin
            if (cnt_after_pop == 2'd0) ent0_d = push_data_i;
            else                       ent1_d = push_data_i;
            cnt_d = cnt_after_pop + 2'd1;
        end
        if (flush_i) cnt_d = 2'd0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ent0_q <= '0;
            ent1_q <= '0;
            cnt_q  <= 2'd0;
        end else begin
            ent0_q <= ent0_d;
            ent1_q <= ent1_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/fft_frame_ctrl.sv
// Frame controller: loads samples into four radix-4 RAM banks, starts the core,
// then streams results out in natural order through a skid buffer.
module fft_frame_ctrl
    import fft_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned N_LOG2 = 10,
    parameter bit          SIGNED = 1'b1
) (
    input  logic              iCLK,
    input  logic              iRESET,
    input  logic [DATA_W-1:0] iS_DATA,
    input  logic              iS_VALID,
    output logic              oS_READY,
    input  logic              iFLUSH,
    output logic              oSRC_EXT,
    output logic [DATA_W:0]   oWR_DATA,
    output logic [N_LOG2-3:0] oWR_ADDR,
    output logic [3:0]        oWR_WE,
    output logic              oSTART,
    input  logic              iCORE_RDY,
    output logic [N_LOG2-3:0] oRD_ADDR,
    input  logic [DATA_W:0]   iRD_DATA_0,
    input  logic [DATA_W:0]   iRD_DATA_1,
    input  logic [DATA_W:0]   iRD_DATA_2,
    input  logic [DATA_W:0]   iRD_DATA_3,
    output logic [DATA_W:0]   oM_DATA,
    output logic              oM_VALID,
    input  logic              iM_READY,
    output logic              oM_LAST,
    output logic              oERR
);

    localparam int unsigned AddrW = N_LOG2 - 2;

    if ((N_LOG2 % 2) != 0 || N_LOG2 < 4) begin : g_bad_n_log2
        $error("fft_frame_ctrl: N_LOG2 must be even and >= 4");
    end

    state_e            state_q, state_d;
    logic [N_LOG2-1:0] n_q, n_d;
    logic [N_LOG2:0]   rd_k_q, rd_k_d;
    logic              pend_q, pend_d, pend_last_q, pend_last_d, err_q, err_d;
    logic [1:0]        pend_bank_q, pend_bank_d, rd_bank, wr_bank, skid_cnt;
    logic [DATA_W:0]   rd_sel;
    logic [DATA_W+1:0] skid_data;
    logic              s_hs, m_pop, rd_issue;

    assign oS_READY = iRESET & ~iFLUSH & (state_q == StLoad);
    assign s_hs     = iS_VALID & oS_READY;
    assign wr_bank  = bank_sel(32'(n_q), N_LOG2);
    assign oWR_WE   = s_hs ? (4'b0001 << wr_bank) : 4'b0000;
    assign oWR_ADDR = n_q[N_LOG2-1:2];
    assign oWR_DATA = !iRESET ? '0 :
                      SIGNED  ? {iS_DATA[DATA_W-1], iS_DATA} : {1'b0, iS_DATA};

    assign oSTART   = (state_q == StStart);
    assign oSRC_EXT = (state_q == StLoad) || (state_q == StUnload);
    assign oERR     = err_q;

    // Result k lives at r = digitrev4(k); bank(r) equals the digit sum of k.
    assign rd_bank  = bank_sel(32'(rd_k_q[N_LOG2-1:0]), N_LOG2);
    assign oRD_ADDR = AddrW'(digit_rev4(32'(rd_k_q[N_LOG2-1:0]), N_LOG2) >> 2);
    assign m_pop    = oM_VALID & iM_READY;
    // Issue only if the read landing next cycle is guaranteed a free slot.
    assign rd_issue = (state_q == StUnload) && !iFLUSH && !rd_k_q[N_LOG2] &&
                      (({1'b0, skid_cnt} + {2'b00, pend_q}) <= (3'd1 + {2'b00, m_pop}));

    always_comb begin
        case (pend_bank_q)
            2'd0:    rd_sel = iRD_DATA_0;
            2'd1:    rd_sel = iRD_DATA_1;
            2'd2:    rd_sel = iRD_DATA_2;
            default: rd_sel = iRD_DATA_3;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        n_d         = n_q;
        rd_k_d      = rd_k_q;
        pend_d      = rd_issue;
        pend_bank_d = rd_bank;
        pend_last_d = (rd_k_q[N_LOG2-1:0] == {N_LOG2{1'b1}});
        err_d       = err_q | (iCORE_RDY & (state_q != StCompute));
        if (iFLUSH) begin
            state_d = StLoad;
            n_d     = '0;
            rd_k_d  = '0;
            pend_d  = 1'b0;
        end else begin
            unique case (state_q)
                StLoad: begin
                    if (s_hs) begin
                        n_d = n_q + 1'b1;
                        if (n_q == {N_LOG2{1'b1}}) state_d = StStart;
                    end
                end
                StStart: state_d = StCompute;
                StCompute: begin
                    if (iCORE_RDY) begin
                        state_d = StUnload;
                        rd_k_d  = '0;
                    end
                end
                StUnload: begin
                    if (rd_issue) rd_k_d = rd_k_q + 1'b1;
                    if (m_pop && oM_LAST) state_d = StLoad;
                end
            endcase
        end
    end

    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            state_q     <= StLoad;
            n_q         <= '0;
            rd_k_q      <= '0;
            pend_q      <= 1'b0;
            pend_bank_q <= 2'd0;
            pend_last_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            rd_k_q      <= rd_k_d;
            pend_q      <= pend_d;
            pend_bank_q <= pend_bank_d;
            pend_last_q <= pend_last_d;
            err_q       <= err_d;
        end
    end

    fft_skid_buf #(
        .Width (DATA_W + 2)
    ) u_skid (
        .clk_i       (iCLK),
        .rst_ni      (iRESET),
        .flush_i     (iFLUSH),
        .push_i      (pend_q & ~iFLUSH),
        .push_data_i ({pend_last_q, rd_sel}),
        .ready_i     (iM_READY),
        .valid_o     (oM_VALID),
        .data_o      (skid_data),
        .count_o     (skid_cnt)
    );

    assign oM_DATA = skid_data[DATA_W:0];
    assign oM_LAST = skid_data[DATA_W+1];

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Directed bench for fft_frame_ctrl at N=16 with a behavioural four-bank RAM.
module tb_fft_frame_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] s_data = '0;
    logic        s_valid = 1'b0, flush = 1'b0, core_rdy = 1'b0, m_ready = 1'b0;
    logic [16:0] rd0, rd1, rd2, rd3;

    logic        s_ready, src_ext, start, m_valid, m_last, err;
    logic [16:0] wr_data, m_data;
    logic [1:0]  wr_addr, rd_addr;
    logic [3:0]  wr_we;

    logic        u_s_ready, u_src_ext, u_start, u_m_valid, u_m_last, u_err;
    logic [16:0] u_wr_data, u_m_data;
    logic [1:0]  u_wr_addr, u_rd_addr;
    logic [3:0]  u_wr_we;

    int n_tests = 0;
    int n_fail  = 0;

    int rev_tab[16]  = '{0, 4, 8, 12, 1, 5, 9, 13, 2, 6, 10, 14, 3, 7, 11, 15};
    int bank_tab[16] = '{0, 1, 2, 3, 1, 2, 3, 0, 2, 3, 0, 1, 3, 0, 1, 2};

    logic [16:0] ram [4][4];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        for (int b = 0; b < 4; b++) if (wr_we[b]) ram[b][wr_addr] <= wr_data;
        rd0 <= ram[0][rd_addr];
        rd1 <= ram[1][rd_addr];
        rd2 <= ram[2][rd_addr];
        rd3 <= ram[3][rd_addr];
    end

    fft_frame_ctrl #(.DATA_W(16), .N_LOG2(4), .SIGNED(1'b1)) dut (
        .iCLK(clk), .iRESET(rst), .iS_DATA(s_data), .iS_VALID(s_valid), .oS_READY(s_ready),
        .iFLUSH(flush), .oSRC_EXT(src_ext), .oWR_DATA(wr_data), .oWR_ADDR(wr_addr),
        .oWR_WE(wr_we), .oSTART(start), .iCORE_RDY(core_rdy), .oRD_ADDR(rd_addr),
        .iRD_DATA_0(rd0), .iRD_DATA_1(rd1), .iRD_DATA_2(rd2), .iRD_DATA_3(rd3),
        .oM_DATA(m_data), .oM_VALID(m_valid), .iM_READY(m_ready), .oM_LAST(m_last),
        .oERR(err)
    );

    fft_frame_ctrl #(.DATA_W(16), .N_LOG2(4), .SIGNED(1'b0)) dut_u (
        .iCLK(clk), .iRESET(rst), .iS_DATA(s_data), .iS_VALID(s_valid), .oS_READY(u_s_ready),
        .iFLUSH(flush), .oSRC_EXT(u_src_ext), .oWR_DATA(u_wr_data), .oWR_ADDR(u_wr_addr),
        .oWR_WE(u_wr_we), .oSTART(u_start), .iCORE_RDY(core_rdy), .oRD_ADDR(u_rd_addr),
        .iRD_DATA_0(rd0), .iRD_DATA_1(rd1), .iRD_DATA_2(rd2), .iRD_DATA_3(rd3),
        .oM_DATA(u_m_data), .oM_VALID(u_m_valid), .iM_READY(m_ready), .oM_LAST(u_m_last),
        .oERR(u_err)
    );

    function automatic logic [15:0] sample_val(input int n);
        return (n == 3) ? 16'h8000 : 16'h1000 + 16'(n);
    endfunction

    function automatic logic [16:0] exp_out(input int k);
        logic [15:0] v;
        v = sample_val(rev_tab[k]);
        return {v[15], v};
    endfunction

    task automatic load_frame(input int first, input int count);
        for (int n = first; n < first + count; n++) begin
            s_valid = 1'b1;
            s_data  = sample_val(n);
            @(posedge clk); #1;
        end
        s_valid = 1'b0;
    endtask

    task automatic test_reset();
        logic [47:0] u_obs;
        s_valid = 1'b1;
        s_data  = 16'h1234;
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if ({s_ready, src_ext, wr_we, start, m_valid, m_last, err} !== 10'b0_1_0000_0_0_0_0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got rdy=%b src=%b we=%b start=%b v=%b last=%b err=%b",
                     s_ready, src_ext, wr_we, start, m_valid, m_last, err);
        end
        n_tests++;
        if ({wr_data, wr_addr, rd_addr, m_data} !== 38'h0) begin
            n_fail++;
            $display("FAIL reset_data: got wd=%h wa=%0d ra=%0d md=%h, want all 0",
                     wr_data, wr_addr, rd_addr, m_data);
        end
        u_obs = {u_s_ready, u_src_ext, u_wr_data, u_wr_addr, u_wr_we, u_start, u_rd_addr,
                 u_m_data, u_m_valid, u_m_last, u_err};
        n_tests++;
        if (u_obs !== {1'b0, 1'b1, 46'h0}) begin
            n_fail++;
            $display("FAIL reset_unsigned: got %h want %h", u_obs, {1'b0, 1'b1, 46'h0});
        end
        s_valid = 1'b0;
        rst     = 1'b1;
        #1;
        n_tests++;
        if (s_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_ready: got %b want 1", s_ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_load();
        for (int n = 0; n < 16; n++) begin
            s_valid = 1'b1;
            s_data  = sample_val(n);
            #1;
            n_tests++;
            if (wr_we !== 4'(1 << bank_tab[n]) || wr_addr !== 2'(n >> 2) || s_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL load_write n=%0d: got we=%b addr=%0d rdy=%b, want we=%b addr=%0d",
                         n, wr_we, wr_addr, s_ready, 4'(1 << bank_tab[n]), n >> 2);
            end
            if (n == 5 || n == 15) begin
                n_tests++;
                if (wr_we !== 4'b0100 || wr_addr !== ((n == 5) ? 2'd1 : 2'd3)) begin
                    n_fail++;
                    $display("FAIL load_bank2 n=%0d: got we=%b addr=%0d, want we=0100",
                             n, wr_we, wr_addr);
                end
            end
            if (n == 3) begin
                n_tests++;
                if (wr_data !== 17'h18000) begin
                    n_fail++;
                    $display("FAIL sign_ext: got %h want 18000", wr_data);
                end
                n_tests++;
                if (u_wr_data !== 17'h08000) begin
                    n_fail++;
                    $display("FAIL zero_ext: got %h want 08000", u_wr_data);
                end
            end
            @(posedge clk); #1;
        end
        s_valid = 1'b0;
        #1;
        n_tests++;
        if (start !== 1'b1 || src_ext !== 1'b0 || s_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL start_pulse: got start=%b src=%b rdy=%b, want 1 0 0",
                     start, src_ext, s_ready);
        end
        @(posedge clk); #1;
        n_tests++;
        if (start !== 1'b0 || src_ext !== 1'b0) begin
            n_fail++;
            $display("FAIL compute_state: got start=%b src=%b, want 0 0", start, src_ext);
        end
    endtask

    task automatic test_unload(input bit rnd);
        int          got = 0;
        int          cyc = 0;
        bit          held = 1'b0;
        logic [16:0] hdata = '0;
        core_rdy = 1'b1;
        @(posedge clk); #1;
        core_rdy = 1'b0;
        while (got < 16 && cyc < 300) begin
            m_ready = rnd ? ($urandom_range(0, 9) < 3) : 1'b1;
            #1;
            if (cyc == 0) begin
                n_tests++;
                if (src_ext !== 1'b1 || m_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL unload_entry: got src=%b v=%b, want 1 0", src_ext, m_valid);
                end
            end
            if (!rnd && cyc == 1) begin
                n_tests++;
                if (rd_addr !== 2'd1 || m_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL k1_addr: got addr=%0d v=%b, want 1 0", rd_addr, m_valid);
                end
            end
            if (!rnd && cyc >= 2) begin
                n_tests++;
                if (m_valid !== 1'b1) begin
                    n_fail++;
                    $display("FAIL unload_gap cyc=%0d: got valid=%b want 1", cyc, m_valid);
                end
            end
            if (held) begin
                n_tests++;
                if (m_valid !== 1'b1 || m_data !== hdata) begin
                    n_fail++;
                    $display("FAIL stall_stable cyc=%0d: got v=%b d=%h want 1 %h",
                             cyc, m_valid, m_data, hdata);
                end
            end
            if (m_valid && m_ready) begin
                n_tests++;
                if (m_data !== exp_out(got) || m_last !== (got == 15)) begin
                    n_fail++;
                    $display("FAIL unload_k%0d rnd=%0d: got d=%h last=%b, want d=%h last=%b",
                             got, rnd, m_data, m_last, exp_out(got), got == 15);
                end
                got++;
            end
            held  = m_valid && !m_ready;
            hdata = m_data;
            @(posedge clk); #1;
            cyc++;
        end
        m_ready = 1'b0;
        #1;
        n_tests++;
        if (got != 16 || s_ready !== 1'b1 || m_valid !== 1'b0 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL unload_done rnd=%0d: got n=%0d rdy=%b v=%b err=%b, want 16 1 0 0",
                     rnd, got, s_ready, m_valid, err);
        end
    endtask

    task automatic test_flush();
        load_frame(0, 7);
        s_valid = 1'b1;
        s_data  = 16'hDEAD;
        flush   = 1'b1;
        #1;
        n_tests++;
        if (s_ready !== 1'b0 || wr_we !== 4'b0000) begin
            n_fail++;
            $display("FAIL flush_no_write: got rdy=%b we=%b, want 0 0000", s_ready, wr_we);
        end
        @(posedge clk); #1;
        flush  = 1'b0;
        s_data = sample_val(0);
        #1;
        n_tests++;
        if (wr_we !== 4'b0001 || wr_addr !== 2'd0) begin
            n_fail++;
            $display("FAIL flush_restart: got we=%b addr=%0d, want 0001 0", wr_we, wr_addr);
        end
        @(posedge clk); #1;
        load_frame(1, 15);
        #1;
        n_tests++;
        if (start !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_frame_len: got start=%b want 1", start);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_err_reset();
        core_rdy = 1'b1;
        m_ready  = 1'b1;
        @(posedge clk); #1;
        core_rdy = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        n_tests++;
        if (m_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_unload_valid: got %b want 1", m_valid);
        end
        rst = 1'b0;
        #1;
        n_tests++;
        if (m_valid !== 1'b0 || m_last !== 1'b0 || src_ext !== 1'b1 || s_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_unload: got v=%b last=%b src=%b rdy=%b, want 0 0 1 0",
                     m_valid, m_last, src_ext, s_ready);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        n_tests++;
        if (s_ready !== 1'b1 || m_valid !== 1'b0 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL after_reset_load: got rdy=%b v=%b err=%b, want 1 0 0",
                     s_ready, m_valid, err);
        end
        core_rdy = 1'b1;
        @(posedge clk); #1;
        core_rdy = 1'b0;
        n_tests++;
        if (err !== 1'b1 || s_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL err_set: got err=%b rdy=%b, want 1 1", err, s_ready);
        end
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if (err !== 1'b1) begin
            n_fail++;
            $display("FAIL err_sticky: got %b want 1", err);
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_unload(1'b0);
        load_frame(0, 16);
        @(posedge clk); #1;
        test_unload(1'b1);
        test_flush();
        test_err_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
